// File: rtl/hazard_md_ctrl.sv
// hazard_md_ctrl: hazard unit for a 5-stage pipeline with a HI/LO mult/div unit.
// It works from pre-decoded Tuse/Tnew fields. It produces stall/flush controls and
// forwarding selects for D, E and M. It also tracks mult/div busy time with a countdown
// FSM, keeps a sticky issue-error flag and counts stalled cycles.
module hazard_md_ctrl #(
  parameter int RA_W     = 5,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4,
  parameter int PERF_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [RA_W-1:0]   i_rs_d,
  input  logic [RA_W-1:0]   i_rt_d,
  input  logic              i_use_rs_d,
  input  logic              i_use_rt_d,
  input  logic [TW-1:0]     i_tuse_rs_d,
  input  logic [TW-1:0]     i_tuse_rt_d,
  input  logic [RA_W-1:0]   i_rs_e,
  input  logic [RA_W-1:0]   i_rt_e,
  input  logic [RA_W-1:0]   i_rt_m,
  input  logic [RA_W-1:0]   i_wa_e,
  input  logic [RA_W-1:0]   i_wa_m,
  input  logic [RA_W-1:0]   i_wa_w,
  input  logic [TW-1:0]     i_tnew_e,
  input  logic [TW-1:0]     i_tnew_m,
  input  logic              i_md_start_e,
  input  logic              i_md_div_e,
  input  logic              i_md_use_d,
  output logic              o_en_pc,
  output logic              o_en_regfd,
  output logic              o_clr_regde,
  output logic [1:0]        o_fwd_rs_d,
  output logic [1:0]        o_fwd_rt_d,
  output logic [1:0]        o_fwd_rs_e,
  output logic [1:0]        o_fwd_rt_e,
  output logic              o_fwd_rt_m,
  output logic              o_md_busy,
  output logic              o_md_err,
  output logic [PERF_W-1:0] o_stall_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  localparam logic [CNT_W-1:0]  L_MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0]  L_DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0]  L_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  L_CNT_ZERO = CNT_W'(0);
  localparam logic [TW-1:0]     L_T_ZERO   = TW'(0);
  localparam logic [RA_W-1:0]   L_RA_ZERO  = RA_W'(0);
  localparam logic [PERF_W-1:0] L_PERF_ONE = PERF_W'(1);

  // Register address match; register zero is hard-wired and never produces a hazard.
  function automatic logic f_match(input logic [RA_W-1:0] r, input logic [RA_W-1:0] wa);
    f_match = (r != L_RA_ZERO) && (r == wa);
  endfunction

  // D-stage source select: E > M > W. A nearer pending match blocks the older stages.
  function automatic logic [1:0] f_fwd_d(input logic m_e, input logic rdy_e,
                                         input logic m_m, input logic rdy_m,
                                         input logic m_w);
    logic [1:0] sel;
    if (m_e) begin
      sel = rdy_e ? 2'd1 : 2'd0;
    end else if (m_m) begin
      sel = rdy_m ? 2'd2 : 2'd0;
    end else if (m_w) begin
      sel = 2'd3;
    end else begin
      sel = 2'd0;
    end
    f_fwd_d = sel;
  endfunction

  // E-stage ALU operand select: M > W. A pending M match blocks W.
  function automatic logic [1:0] f_fwd_e(input logic m_m, input logic rdy_m, input logic m_w);
    logic [1:0] sel;
    if (m_m) begin
      sel = rdy_m ? 2'd2 : 2'd0;
    end else if (m_w) begin
      sel = 2'd3;
    end else begin
      sel = 2'd0;
    end
    f_fwd_e = sel;
  endfunction

  // Data stall for one source: its value arrives later than the instruction needs it.
  function automatic logic f_data_stall(input logic use_r, input logic m_e, input logic m_m,
                                        input logic [TW-1:0] tnew_e, input logic [TW-1:0] tnew_m,
                                        input logic [TW-1:0] tuse);
    f_data_stall = use_r && ((m_e && (tnew_e > tuse)) || (m_m && (tnew_m > tuse)));
  endfunction

  md_state_t         r_state;
  md_state_t         w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_md_err;
  logic              w_md_err_nxt;
  logic [PERF_W-1:0] r_stall_cnt;
  logic              w_md_busy;

  logic              w_rdy_e;
  logic              w_rdy_m;
  logic              w_stall_rs;
  logic              w_stall_rt;
  logic              w_stall_md;
  logic              w_stall;
  logic [1:0]        w_fwd_rs_d;
  logic [1:0]        w_fwd_rt_d;
  logic [1:0]        w_fwd_rs_e;
  logic [1:0]        w_fwd_rt_e;
  logic              w_fwd_rt_m;

  // Stall detection and forwarding selects, purely combinational from stage fields.
  always_comb begin
    w_rdy_e    = (i_tnew_e == L_T_ZERO);
    w_rdy_m    = (i_tnew_m == L_T_ZERO);
    w_stall_rs = f_data_stall(i_use_rs_d, f_match(i_rs_d, i_wa_e), f_match(i_rs_d, i_wa_m),
                              i_tnew_e, i_tnew_m, i_tuse_rs_d);
    w_stall_rt = f_data_stall(i_use_rt_d, f_match(i_rt_d, i_wa_e), f_match(i_rt_d, i_wa_m),
                              i_tnew_e, i_tnew_m, i_tuse_rt_d);
    w_stall_md = i_md_use_d && (i_md_start_e || w_md_busy);
    w_stall    = w_stall_rs || w_stall_rt || w_stall_md;
    w_fwd_rs_d = f_fwd_d(f_match(i_rs_d, i_wa_e), w_rdy_e,
                         f_match(i_rs_d, i_wa_m), w_rdy_m, f_match(i_rs_d, i_wa_w));
    w_fwd_rt_d = f_fwd_d(f_match(i_rt_d, i_wa_e), w_rdy_e,
                         f_match(i_rt_d, i_wa_m), w_rdy_m, f_match(i_rt_d, i_wa_w));
    w_fwd_rs_e = f_fwd_e(f_match(i_rs_e, i_wa_m), w_rdy_m, f_match(i_rs_e, i_wa_w));
    w_fwd_rt_e = f_fwd_e(f_match(i_rt_e, i_wa_m), w_rdy_m, f_match(i_rt_e, i_wa_w));
    w_fwd_rt_m = f_match(i_rt_m, i_wa_w);
  end

  // Pipeline control outputs.
  always_comb begin
    o_en_pc     = ~w_stall;
    o_en_regfd  = ~w_stall;
    o_clr_regde = w_stall;
    o_fwd_rs_d  = w_fwd_rs_d;
    o_fwd_rt_d  = w_fwd_rt_d;
    o_fwd_rs_e  = w_fwd_rs_e;
    o_fwd_rt_e  = w_fwd_rt_e;
    o_fwd_rt_m  = w_fwd_rt_m;
  end

  // MD FSM state, countdown and sticky error registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= L_CNT_ZERO;
      r_md_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_md_err <= w_md_err_nxt;
    end
  end

  // MD FSM next state: load the latency on issue, count down while busy.
  // A start that arrives while busy does not reload the counter; it only sets the error flag.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_md_err_nxt = r_md_err;
    case (r_state)
      ST_IDLE: begin
        if (i_md_start_e) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = i_md_div_e ? L_DIV_CNT : L_MULT_CNT;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = L_CNT_ZERO;
        end
      end
      ST_BUSY: begin
        if (r_cnt == L_CNT_ONE) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = L_CNT_ZERO;
        end else begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = r_cnt - L_CNT_ONE;
        end
        if (i_md_start_e) begin
          w_md_err_nxt = 1'b1;
        end else begin
          w_md_err_nxt = r_md_err;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_cnt_nxt    = L_CNT_ZERO;
        w_md_err_nxt = r_md_err;
      end
    endcase
  end

  // MD FSM outputs, decoded from the state register only.
  always_comb begin
    case (r_state)
      ST_BUSY: w_md_busy = 1'b1;
      ST_IDLE: w_md_busy = 1'b0;
      default: w_md_busy = 1'b0;
    endcase
    o_md_busy = w_md_busy;
    o_md_err  = r_md_err;
  end

  // Stall-cycle performance counter; wraps naturally at its width.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_cnt <= {PERF_W{1'b0}};
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + L_PERF_ONE;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Table-driven bench for hazard_md_ctrl plus directed mult/div and reset sequences.
module tb_hazard_md_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_d, rt_d, rs_e, rt_e, rt_m, wa_e, wa_m, wa_w;
  logic        use_rs_d, use_rt_d, md_start_e, md_div_e, md_use_d;
  logic [1:0]  tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
  logic        en_pc, en_regfd, clr_regde, fwd_rt_m, md_busy, md_err;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic [31:0] stall_cnt;

  int n_pass = 0;
  int n_total = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_md_ctrl dut (
    .i_clk(clk), .i_reset(reset),
    .i_rs_d(rs_d), .i_rt_d(rt_d), .i_use_rs_d(use_rs_d), .i_use_rt_d(use_rt_d),
    .i_tuse_rs_d(tuse_rs_d), .i_tuse_rt_d(tuse_rt_d),
    .i_rs_e(rs_e), .i_rt_e(rt_e), .i_rt_m(rt_m),
    .i_wa_e(wa_e), .i_wa_m(wa_m), .i_wa_w(wa_w),
    .i_tnew_e(tnew_e), .i_tnew_m(tnew_m),
    .i_md_start_e(md_start_e), .i_md_div_e(md_div_e), .i_md_use_d(md_use_d),
    .o_en_pc(en_pc), .o_en_regfd(en_regfd), .o_clr_regde(clr_regde),
    .o_fwd_rs_d(fwd_rs_d), .o_fwd_rt_d(fwd_rt_d),
    .o_fwd_rs_e(fwd_rs_e), .o_fwd_rt_e(fwd_rt_e), .o_fwd_rt_m(fwd_rt_m),
    .o_md_busy(md_busy), .o_md_err(md_err), .o_stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, rt_m, wa_e, wa_m, wa_w;
    logic       use_rs, use_rt, md_use;
    logic [1:0] tuse_rs, tuse_rt, tnew_e, tnew_m;
    logic       x_stall;
    logic [1:0] x_rs_d, x_rt_d, x_rs_e, x_rt_e;
    logic       x_rt_m;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  vec_t z;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic clr_inputs();
    rs_d = 5'd0; rt_d = 5'd0; rs_e = 5'd0; rt_e = 5'd0; rt_m = 5'd0;
    wa_e = 5'd0; wa_m = 5'd0; wa_w = 5'd0;
    use_rs_d = 1'b0; use_rt_d = 1'b0; tuse_rs_d = 2'd0; tuse_rt_d = 2'd0;
    tnew_e = 2'd0; tnew_m = 2'd0;
    md_start_e = 1'b0; md_div_e = 1'b0; md_use_d = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    rs_d = v.rs_d; rt_d = v.rt_d; rs_e = v.rs_e; rt_e = v.rt_e; rt_m = v.rt_m;
    wa_e = v.wa_e; wa_m = v.wa_m; wa_w = v.wa_w;
    use_rs_d = v.use_rs; use_rt_d = v.use_rt; md_use_d = v.md_use;
    tuse_rs_d = v.tuse_rs; tuse_rt_d = v.tuse_rt; tnew_e = v.tnew_e; tnew_m = v.tnew_m;
  endtask

  task automatic chk_stall(input string nm, input logic s);
    chk({nm, " clr_regde"}, {31'd0, clr_regde}, {31'd0, s});
    chk({nm, " en_pc"}, {31'd0, en_pc}, {31'd0, ~s});
    chk({nm, " en_regfd"}, {31'd0, en_regfd}, {31'd0, ~s});
  endtask

  initial begin
    z = '{default: '0};
    for (int i = 0; i < NV; i++) vecs[i] = z;
    // v0: idle
    // v1: load-use on rs through E
    vecs[1].wa_e = 5'd5; vecs[1].tnew_e = 2'd2; vecs[1].rs_d = 5'd5; vecs[1].use_rs = 1'b1;
    vecs[1].tuse_rs = 2'd1; vecs[1].x_stall = 1'b1;
    // v2: ALU B from M
    vecs[2].wa_m = 5'd8; vecs[2].rt_e = 5'd8; vecs[2].x_rt_e = 2'd2;
    // v3: M beats W for ALU B
    vecs[3].wa_m = 5'd8; vecs[3].wa_w = 5'd8; vecs[3].rt_e = 5'd8; vecs[3].x_rt_e = 2'd2;
    // v4: register zero never stalls or forwards
    vecs[4].tnew_e = 2'd2; vecs[4].use_rs = 1'b1;
    // v5: D rs from E
    vecs[5].rs_d = 5'd3; vecs[5].wa_e = 5'd3; vecs[5].use_rs = 1'b1; vecs[5].x_rs_d = 2'd1;
    // v6: D rt from M, W ignored
    vecs[6].rt_d = 5'd7; vecs[6].wa_m = 5'd7; vecs[6].wa_w = 5'd7; vecs[6].use_rt = 1'b1;
    vecs[6].x_rt_d = 2'd2;
    // v7: W forwarding to D, E and M
    vecs[7].rs_d = 5'd9; vecs[7].rs_e = 5'd9; vecs[7].rt_m = 5'd9; vecs[7].wa_w = 5'd9;
    vecs[7].x_rs_d = 2'd3; vecs[7].x_rs_e = 2'd3; vecs[7].x_rt_m = 1'b1;
    // v8: rt stall through M; pending M blocks W
    vecs[8].rt_d = 5'd4; vecs[8].wa_m = 5'd4; vecs[8].tnew_m = 2'd1; vecs[8].wa_w = 5'd4;
    vecs[8].use_rt = 1'b1; vecs[8].x_stall = 1'b1;
    // v9: tnew == tuse is not a stall; pending E blocks
    vecs[9].rs_d = 5'd6; vecs[9].wa_e = 5'd6; vecs[9].tnew_e = 2'd1; vecs[9].tuse_rs = 2'd1;
    vecs[9].use_rs = 1'b1;
    // v10: match but rs not read
    vecs[10].rs_d = 5'd6; vecs[10].wa_e = 5'd6; vecs[10].tnew_e = 2'd2;
    // v11: md user with idle unit
    vecs[11].md_use = 1'b1;
    // v12: E beats M for D rs
    vecs[12].rs_d = 5'd2; vecs[12].wa_e = 5'd2; vecs[12].wa_m = 5'd2; vecs[12].use_rs = 1'b1;
    vecs[12].x_rs_d = 2'd1;
    // v13: ALU A from M
    vecs[13].rs_e = 5'd10; vecs[13].wa_m = 5'd10; vecs[13].x_rs_e = 2'd2;
    // v14: rt stall via E with tuse 0, tnew 1
    vecs[14].rt_d = 5'd11; vecs[14].wa_e = 5'd11; vecs[14].tnew_e = 2'd1; vecs[14].use_rt = 1'b1;
    vecs[14].x_stall = 1'b1;

    clr_inputs();
    reset = 1'b1;
    #12;
    chk("reset busy", {31'd0, md_busy}, 32'd0);
    chk("reset err", {31'd0, md_err}, 32'd0);
    chk("reset stall_cnt", stall_cnt, 32'd0);
    chk_stall("reset", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Combinational table; one clock edge per vector so stalls reach the counter.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk_stall($sformatf("v%0d", i), vecs[i].x_stall);
      chk($sformatf("v%0d fwd_rs_d", i), {30'd0, fwd_rs_d}, {30'd0, vecs[i].x_rs_d});
      chk($sformatf("v%0d fwd_rt_d", i), {30'd0, fwd_rt_d}, {30'd0, vecs[i].x_rt_d});
      chk($sformatf("v%0d fwd_rs_e", i), {30'd0, fwd_rs_e}, {30'd0, vecs[i].x_rs_e});
      chk($sformatf("v%0d fwd_rt_e", i), {30'd0, fwd_rt_e}, {30'd0, vecs[i].x_rt_e});
      chk($sformatf("v%0d fwd_rt_m", i), {31'd0, fwd_rt_m}, {31'd0, vecs[i].x_rt_m});
      if (vecs[i].x_stall) exp_cnt++;
    end
    @(negedge clk);
    clr_inputs();
    #1;
    chk("table stall_cnt", stall_cnt, 32'(exp_cnt));

    // Div then mfhi: stall in the issue cycle plus 10 busy cycles.
    @(negedge clk);
    md_start_e = 1'b1; md_div_e = 1'b1; md_use_d = 1'b1;
    #1;
    chk_stall("div issue", 1'b1);
    chk("div issue busy", {31'd0, md_busy}, 32'd0);
    @(negedge clk);
    md_start_e = 1'b0; md_div_e = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("div busy c%0d", i), {31'd0, md_busy}, 32'd1);
      chk($sformatf("div stall c%0d", i), {31'd0, clr_regde}, 32'd1);
      @(negedge clk);
    end
    #1;
    chk("div done busy", {31'd0, md_busy}, 32'd0);
    chk_stall("div done", 1'b0);
    exp_cnt += 11;
    chk("div stall_cnt", stall_cnt, 32'(exp_cnt));
    md_use_d = 1'b0;
    chk("div no err", {31'd0, md_err}, 32'd0);

    // Mult, then a second (div) start while busy: error set, end time unchanged.
    @(negedge clk);
    md_start_e = 1'b1; md_div_e = 1'b0;
    @(negedge clk);
    md_start_e = 1'b0;
    #1 chk("mult busy 1", {31'd0, md_busy}, 32'd1);
    @(negedge clk);
    md_start_e = 1'b1; md_div_e = 1'b1;
    @(negedge clk);
    md_start_e = 1'b0; md_div_e = 1'b0;
    #1;
    chk("restart err", {31'd0, md_err}, 32'd1);
    chk("mult busy 3", {31'd0, md_busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1 chk("mult busy 5", {31'd0, md_busy}, 32'd1);
    @(negedge clk);
    #1;
    chk("mult end busy", {31'd0, md_busy}, 32'd0);
    chk("err sticky", {31'd0, md_err}, 32'd1);
    chk("mult stall_cnt", stall_cnt, 32'(exp_cnt));

    // Reset in the middle of a mult (cnt == 3), with a stall vector on the inputs.
    @(negedge clk);
    md_start_e = 1'b1;
    @(negedge clk);
    md_start_e = 1'b0;
    @(negedge clk);
    @(negedge clk);
    apply(vecs[1]);
    reset = 1'b1;
    #1;
    chk("mid reset busy", {31'd0, md_busy}, 32'd0);
    chk("mid reset err", {31'd0, md_err}, 32'd0);
    chk("mid reset stall_cnt", stall_cnt, 32'd0);
    chk_stall("mid reset comb", 1'b1);
    @(negedge clk);
    #1 chk("held reset stall_cnt", stall_cnt, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post reset stall_cnt", stall_cnt, 32'd1);
    chk("post reset busy", {31'd0, md_busy}, 32'd0);
    clr_inputs();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
